// File: rtl/qupls_checkpoint_alloc.sv
// Rename-map checkpoint allocator: ring of NCHECK slots in Qupls_checkpointRam.
// Optional statistics counters are enabled by defining QUPLS_CPALLOC_STATS_EN.
module qupls_checkpoint_alloc #(
  parameter int NCHECK = 16,
  parameter int AREGS  = 64,
  parameter int BANKS  = 4,
  parameter int PREGS  = 512,
  parameter int CW     = $clog2(NCHECK),
  parameter int RBIT   = $clog2(PREGS),
  parameter int MW     = AREGS*BANKS*RBIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  input  logic [MW-1:0]          alloc_map,
  output logic                   alloc_ack,
  output logic [CW-1:0]          alloc_cndx,
  output logic                   full,
  input  logic                   free_req,
  input  logic                   restore_req,
  input  logic [CW-1:0]          restore_cndx,
  output logic                   restore_done,
  output logic [MW-1:0]          restore_map,
  output logic                   restore_err,
  output logic [CW:0]            live_cnt,
  output logic                   cpram_ena,
  output logic [AREGS*BANKS-1:0] cpram_wea,
  output logic [5:0]             cpram_addra,
  output logic [MW-1:0]          cpram_dina,
  output logic                   cpram_enb,
  output logic [5:0]             cpram_addrb,
  input  logic [MW-1:0]          cpram_doutb
`ifdef QUPLS_CPALLOC_STATS_EN
  ,
  output logic [31:0]            stat_alloc,
  output logic [31:0]            stat_full_stall,
  output logic [31:0]            stat_restore
`endif
);

  logic [CW:0]   head;
  logic [CW:0]   tail;
  logic [CW-1:0] rel;
  logic          hit;
  logic          rs_go;
  logic          free_ok;

  assign live_cnt = tail - head;
  assign full     = live_cnt == (CW+1)'(NCHECK);

  // Distance from the oldest slot decides liveness and the new tail's wrap bit.
  assign rel   = restore_cndx - head[CW-1:0];
  assign hit   = {1'b0, rel} < live_cnt;
  assign rs_go = restore_req & hit;

  assign alloc_ack  = alloc_req & ~full & ~restore_req & ~rst;
  assign alloc_cndx = tail[CW-1:0];

  // Restoring the head slot already releases it, so a same-cycle free is dropped.
  assign free_ok = free_req & (live_cnt != '0) & ~(rs_go & (rel == '0));

  assign cpram_ena   = alloc_ack;
  assign cpram_wea   = {(AREGS*BANKS){alloc_ack}};
  assign cpram_addra = 6'(tail[CW-1:0]);
  assign cpram_dina  = alloc_map;
  assign cpram_enb   = rs_go & ~rst;
  assign cpram_addrb = 6'(restore_cndx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      restore_done <= 1'b0;
      restore_err  <= 1'b0;
      restore_map  <= '0;
    end else begin
      if (free_ok)
        head <= head + (CW+1)'(1);
      if (rs_go)
        tail <= head + {1'b0, rel};
      else if (alloc_ack)
        tail <= tail + (CW+1)'(1);
      restore_done <= rs_go;
      restore_err  <= restore_req & ~hit;
      if (rs_go)
        restore_map <= cpram_doutb;
    end
  end

`ifdef QUPLS_CPALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_alloc      <= '0;
      stat_full_stall <= '0;
      stat_restore    <= '0;
    end else begin
      if (alloc_ack && ~&stat_alloc)
        stat_alloc <= stat_alloc + 32'd1;
      if (alloc_req && full && ~&stat_full_stall)
        stat_full_stall <= stat_full_stall + 32'd1;
      if (restore_done && ~&stat_restore)
        stat_restore <= stat_restore + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qupls_checkpoint_alloc.sv
// Bench for qupls_checkpoint_alloc: queue-based slot model plus a behavioural RAM.
// Stat ports are exercised when QUPLS_CPALLOC_STATS_EN is defined.
module tb_qupls_checkpoint_alloc;
  localparam int NCHECK = 16;
  localparam int AREGS  = 64;
  localparam int BANKS  = 4;
  localparam int PREGS  = 512;
  localparam int CW     = 4;
  localparam int MW     = AREGS*BANKS*9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_req;
  logic [MW-1:0]          alloc_map;
  logic                   alloc_ack;
  logic [CW-1:0]          alloc_cndx;
  logic                   full;
  logic                   free_req;
  logic                   restore_req;
  logic [CW-1:0]          restore_cndx;
  logic                   restore_done;
  logic [MW-1:0]          restore_map;
  logic                   restore_err;
  logic [CW:0]            live_cnt;
  logic                   cpram_ena;
  logic [AREGS*BANKS-1:0] cpram_wea;
  logic [5:0]             cpram_addra;
  logic [MW-1:0]          cpram_dina;
  logic                   cpram_enb;
  logic [5:0]             cpram_addrb;
  logic [MW-1:0]          cpram_doutb;
`ifdef QUPLS_CPALLOC_STATS_EN
  logic [31:0]            stat_alloc;
  logic [31:0]            stat_full_stall;
  logic [31:0]            stat_restore;
`endif

  qupls_checkpoint_alloc #(
    .NCHECK(NCHECK), .AREGS(AREGS), .BANKS(BANKS), .PREGS(PREGS)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_map(alloc_map),
    .alloc_ack(alloc_ack), .alloc_cndx(alloc_cndx), .full(full),
    .free_req(free_req),
    .restore_req(restore_req), .restore_cndx(restore_cndx),
    .restore_done(restore_done), .restore_map(restore_map),
    .restore_err(restore_err), .live_cnt(live_cnt),
    .cpram_ena(cpram_ena), .cpram_wea(cpram_wea),
    .cpram_addra(cpram_addra), .cpram_dina(cpram_dina),
    .cpram_enb(cpram_enb), .cpram_addrb(cpram_addrb),
    .cpram_doutb(cpram_doutb)
`ifdef QUPLS_CPALLOC_STATS_EN
    ,
    .stat_alloc(stat_alloc),
    .stat_full_stall(stat_full_stall),
    .stat_restore(stat_restore)
`endif
  );

  always #5 clk = ~clk;

  // Checkpoint RAM: write on port A at the edge, zero-latency read on port B.
  logic [MW-1:0] ram [64];
  always @(posedge clk)
    if (cpram_ena && (&cpram_wea))
      ram[cpram_addra] <= cpram_dina;
  assign cpram_doutb = ram[cpram_addrb];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: live slots oldest-first, next slot to hand out, saved maps.
  int            q[$];
  int            nxt;
  logic [MW-1:0] mem [NCHECK];
  logic [MW-1:0] exp_map;
  int            st_alloc, st_stall, st_rest;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_map();
    n_cmp++;
    assert (restore_map === exp_map) else begin
      n_bad++;
      $error("FAIL restore_map: observed low %0h expected low %0h",
             restore_map[63:0], exp_map[63:0]);
    end
  endtask

  function automatic logic [MW-1:0] rand_map();
    logic [MW-1:0] m;
    for (int i = 0; i < MW/32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [MW-1:0] pat_map(input int s);
    logic [MW-1:0] m;
    for (int i = 0; i < MW/8; i++) m[i*8 +: 8] = 8'(s*17);
    return m;
  endfunction

  task automatic model_clear();
    q.delete();
    nxt = 0;
    exp_map = '0;
    st_alloc = 0;
    st_stall = 0;
    st_rest = 0;
  endtask

  // One cycle: drive, check combinational outputs, clock, check registered ones.
  task automatic step(input bit a, input bit f, input bit r,
                      input logic [CW-1:0] rc, input logic [MW-1:0] m);
    int p;
    int pre_n;
    bit pre_full, ack, done, err;
    alloc_req = a;
    free_req = f;
    restore_req = r;
    restore_cndx = rc;
    alloc_map = m;
    #1;
    pre_n = q.size();
    pre_full = (pre_n == NCHECK);
    p = -1;
    foreach (q[i]) if (q[i] == int'(rc)) p = i;
    ack = a && !pre_full && !r;
    chk("live_cnt", 64'(live_cnt), 64'(pre_n));
    chk("full", 64'(full), 64'(pre_full));
    chk("alloc_ack", 64'(alloc_ack), 64'(ack));
    chk("cpram_ena", 64'(cpram_ena), 64'(ack));
    if (ack) begin
      chk("alloc_cndx", 64'(alloc_cndx), 64'(nxt));
      chk("cpram_addra", 64'(cpram_addra), 64'(nxt));
      chk("cpram_wea", 64'(&cpram_wea), 64'(1));
    end else begin
      chk("cpram_wea_idle", 64'(|cpram_wea), 64'(0));
    end
    chk("cpram_enb", 64'(cpram_enb), 64'(r && p >= 0));
    if (r && p >= 0) chk("cpram_addrb", 64'(cpram_addrb), 64'(rc));
    @(posedge clk);
    done = r && p >= 0;
    err = r && p < 0;
    if (ack) st_alloc++;
    if (a && pre_full) st_stall++;
    if (done) st_rest++;
    if (done) begin
      exp_map = mem[rc];
      while (q.size() > p) void'(q.pop_back());
      nxt = int'(rc);
      if (f && pre_n != 0 && p != 0) void'(q.pop_front());
    end else begin
      if (f && pre_n != 0) void'(q.pop_front());
      if (ack) begin
        mem[nxt] = m;
        q.push_back(nxt);
        nxt = (nxt + 1) % NCHECK;
      end
    end
    #1;
    chk("restore_done", 64'(restore_done), 64'(done));
    chk("restore_err", 64'(restore_err), 64'(err));
    chk_map();
    chk("live_after", 64'(live_cnt), 64'(q.size()));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    alloc_req = 1'b0;
    free_req = 1'b0;
    restore_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

`ifdef QUPLS_CPALLOC_STATS_EN
  task automatic chk_stats();
    chk("stat_alloc", 64'(stat_alloc), 64'(st_alloc));
    chk("stat_full_stall", 64'(stat_full_stall), 64'(st_stall));
    chk("stat_restore", 64'(stat_restore), 64'(st_rest));
  endtask
`endif

  initial begin
    rst = 1'b1;
    alloc_req = 1'b0;
    free_req = 1'b0;
    restore_req = 1'b0;
    restore_cndx = '0;
    alloc_map = '0;
    #2;
    chk("rst_live", 64'(live_cnt), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_ack", 64'(alloc_ack), 64'(0));
    chk("rst_done", 64'(restore_done), 64'(0));
    chk("rst_err", 64'(restore_err), 64'(0));
    chk("rst_map", 64'(|restore_map), 64'(0));
    chk("rst_ena", 64'(cpram_ena), 64'(0));
    chk("rst_enb", 64'(cpram_enb), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();

    // Fill all slots, then one more request while full.
    for (int i = 0; i < NCHECK; i++) step(1'b1, 1'b0, 1'b0, '0, rand_map());
    step(1'b1, 1'b0, 1'b0, '0, rand_map());
    // Full: free and alloc together is still denied; then wrap to slot 0.
    step(1'b1, 1'b1, 1'b0, '0, rand_map());
    step(1'b1, 1'b0, 1'b0, '0, rand_map());
    chk("wrap_cndx_next", 64'(alloc_cndx), 64'(1));
    // Drain past empty so a stray free is ignored.
    for (int i = 0; i < NCHECK + 2; i++) step(1'b0, 1'b1, 1'b0, '0, '0);

    // Pattern maps in slots 0..5, restore slot 3.
    do_reset();
    for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 1'b0, '0, pat_map(s));
    step(1'b0, 1'b0, 1'b1, 4'd3, '0);
    chk("pat3_map", 64'(restore_map[63:0]), 64'(pat_map(3)));
    step(1'b1, 1'b0, 1'b0, '0, rand_map());
    // Back-to-back restores.
    step(1'b0, 1'b0, 1'b1, 4'd2, '0);
    step(1'b0, 1'b0, 1'b1, 4'd1, '0);
    idle();

    // head=2, tail=4: non-live restore, then restore of head with a free.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, rand_map());
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 4'd7, '0);
    step(1'b0, 1'b1, 1'b1, 4'd2, '0);
    step(1'b1, 1'b0, 1'b0, '0, rand_map());

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 12, 4'($urandom_range(0, 15)),
           rand_map());
    idle();
`ifdef QUPLS_CPALLOC_STATS_EN
    chk_stats();
`endif

    // Reset arriving while a restore is in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, rand_map());
    alloc_req = 1'b1;
    restore_req = 1'b1;
    restore_cndx = 4'd1;
    #1 chk("mid_enb_pre", 64'(cpram_enb), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_ena", 64'(cpram_ena), 64'(0));
    chk("mid_enb", 64'(cpram_enb), 64'(0));
    chk("mid_ack", 64'(alloc_ack), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    alloc_req = 1'b0;
    restore_req = 1'b0;
    #1;
    model_clear();
    chk("mid_done", 64'(restore_done), 64'(0));
    chk("mid_live", 64'(live_cnt), 64'(0));
    chk("mid_full", 64'(full), 64'(0));
    @(posedge clk);
    #1 chk("mid_done_late", 64'(restore_done), 64'(0));
    idle();

`ifdef QUPLS_CPALLOC_STATS_EN
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, '0, rand_map());
    idle();
    chk_stats();
    chk("stat_alloc_16", 64'(stat_alloc), 64'(16));
    chk("stat_stall_4", 64'(stat_full_stall), 64'(4));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
